// File: rtl/cpu_fetch_ifid.sv
// +--------------------------------------------------------------------------+
// | cpu_fetch_ifid: MIPS instruction fetch stage with IF/ID pipeline register|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_fetch_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        hazard_detected,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [5:0]  ifid_opcode,
    output logic [31:0] ifid_pc_plus4,
    output logic        fetch_busy
);

    localparam logic [1:0] c_st_start      = 2'd0;
    localparam logic [1:0] c_st_req        = 2'd1;
    localparam logic [1:0] c_st_held       = 2'd2;
    localparam logic [1:0] c_st_wait_drain = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_drain_addr;
    logic [31:0] r_skid;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc_plus4;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_drain_addr_nxt;
    logic [31:0] w_skid_nxt;
    logic        w_ifid_valid_nxt;
    logic [31:0] w_ifid_instr_nxt;
    logic [31:0] w_ifid_pc_plus4_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_target;

    assign w_pc_plus4        = r_pc + 32'd4;
    assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_start;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_start: w_state_nxt = c_st_req;
            c_st_req: begin
                if (redirect_valid) begin
                    w_state_nxt = imem_ack ? c_st_req : c_st_wait_drain;
                end else if (imem_ack && hazard_detected) begin
                    w_state_nxt = c_st_held;
                end
            end
            c_st_held: begin
                if (redirect_valid || !hazard_detected) begin
                    w_state_nxt = c_st_req;
                end
            end
            c_st_wait_drain: begin
                if (imem_ack) begin
                    w_state_nxt = c_st_req;
                end
            end
            default: w_state_nxt = c_st_start;
        endcase
    end

    // Datapath next values; the PC only advances when a word enters IF/ID.
    always_comb begin
        w_pc_nxt            = r_pc;
        w_drain_addr_nxt    = r_drain_addr;
        w_skid_nxt          = r_skid;
        w_ifid_valid_nxt    = r_ifid_valid;
        w_ifid_instr_nxt    = r_ifid_instr;
        w_ifid_pc_plus4_nxt = r_ifid_pc_plus4;
        case (r_state)
            c_st_start: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_target;
                end
            end
            c_st_req: begin
                if (redirect_valid) begin
                    w_pc_nxt         = w_redirect_target;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = NOP_INSTR;
                    if (!imem_ack) begin
                        w_drain_addr_nxt = r_pc;
                    end
                end else if (imem_ack && !hazard_detected) begin
                    w_ifid_instr_nxt    = imem_rdata;
                    w_ifid_pc_plus4_nxt = w_pc_plus4;
                    w_ifid_valid_nxt    = 1'b1;
                    w_pc_nxt            = w_pc_plus4;
                end else if (imem_ack && hazard_detected) begin
                    w_skid_nxt = imem_rdata;
                end else if (!hazard_detected) begin
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = NOP_INSTR;
                end
            end
            c_st_held: begin
                if (redirect_valid) begin
                    w_pc_nxt         = w_redirect_target;
                    w_ifid_valid_nxt = 1'b0;
                    w_ifid_instr_nxt = NOP_INSTR;
                end else if (!hazard_detected) begin
                    w_ifid_instr_nxt    = r_skid;
                    w_ifid_pc_plus4_nxt = w_pc_plus4;
                    w_ifid_valid_nxt    = 1'b1;
                    w_pc_nxt            = w_pc_plus4;
                end
            end
            c_st_wait_drain: begin
                // The drained word belongs to the old path and is discarded.
                if (redirect_valid) begin
                    w_pc_nxt = w_redirect_target;
                end
                w_ifid_valid_nxt = 1'b0;
                w_ifid_instr_nxt = NOP_INSTR;
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_drain_addr    <= 32'd0;
            r_skid          <= 32'd0;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus4 <= 32'd0;
        end else begin
            r_pc            <= w_pc_nxt;
            r_drain_addr    <= w_drain_addr_nxt;
            r_skid          <= w_skid_nxt;
            r_ifid_valid    <= w_ifid_valid_nxt;
            r_ifid_instr    <= w_ifid_instr_nxt;
            r_ifid_pc_plus4 <= w_ifid_pc_plus4_nxt;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = r_pc;
        fetch_busy = 1'b0;
        case (r_state)
            c_st_req: begin
                imem_req = 1'b1;
            end
            c_st_held: begin
                fetch_busy = 1'b1;
            end
            c_st_wait_drain: begin
                imem_req   = 1'b1;
                imem_addr  = r_drain_addr;
                fetch_busy = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_opcode   = r_ifid_instr[31:26];
    assign ifid_pc_plus4 = r_ifid_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_ifid.sv
// +--------------------------------------------------------------------------+
// | tb_cpu_fetch_ifid: directed self-checking bench for cpu_fetch_ifid       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_fetch_ifid;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        hazard_detected;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [5:0]  ifid_opcode;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_busy;

    int vectors;
    int miscompares;

    cpu_fetch_ifid #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .hazard_detected (hazard_detected),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_opcode     (ifid_opcode),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .fetch_busy      (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic ack, input logic [31:0] rdata, input logic haz,
                       input logic redir, input logic [31:0] rpc);
        imem_ack        = ack;
        imem_rdata      = rdata;
        hazard_detected = haz;
        redirect_valid  = redir;
        redirect_pc     = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        tick();
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_instr", ifid_instr, NOP);
        check("rst_pp4", ifid_pc_plus4, 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        #1;
        check("start_req", 32'(imem_req), 32'd0);
        tick();

        // Zero-wait memory: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h2001_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            check("t1_addr", imem_addr, 32'(i * 4));
            tick();
            check("t1_valid", 32'(ifid_valid), 32'd1);
            check("t1_pp4", ifid_pc_plus4, 32'(i * 4 + 4));
            check("t1_instr", ifid_instr, 32'h2001_0000 + 32'(i));
        end

        // Ack delayed three cycles on 0x10
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
            check("t2_addr", imem_addr, 32'h10);
            tick();
            check("t2_bubble", 32'(ifid_valid), 32'd0);
            check("t2_nop", ifid_instr, NOP);
        end
        drv(1'b1, 32'h8C02_0008, 1'b0, 1'b0, 32'd0);
        check("t2_addr_ack", imem_addr, 32'h10);
        tick();
        check("t2_valid", 32'(ifid_valid), 32'd1);
        check("t2_pp4", ifid_pc_plus4, 32'h14);
        check("t2_instr", ifid_instr, 32'h8C02_0008);

        // Hazard while the ack arrives: word parked, IF/ID frozen
        drv(1'b1, 32'hAC01_0004, 1'b1, 1'b0, 32'd0);
        check("t3_addr", imem_addr, 32'h14);
        tick();
        check("t3_busy", 32'(fetch_busy), 32'd1);
        check("t3_req_held", 32'(imem_req), 32'd0);
        check("t3_hold_instr", ifid_instr, 32'h8C02_0008);
        check("t3_hold_valid", 32'(ifid_valid), 32'd1);
        drv(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        check("t3_busy2", 32'(fetch_busy), 32'd1);
        check("t3_hold_instr2", ifid_instr, 32'h8C02_0008);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("t3_instr", ifid_instr, 32'hAC01_0004);
        check("t3_opcode", 32'(ifid_opcode), 32'h2B);
        check("t3_pp4", ifid_pc_plus4, 32'h18);
        check("t3_busy_clr", 32'(fetch_busy), 32'd0);
        check("t3_next_addr", imem_addr, 32'h18);
        check("t3_next_req", 32'(imem_req), 32'd1);

        // Redirect while the request to 0x20 is pending
        drv(1'b1, 32'h0000_1020, 1'b0, 1'b0, 32'd0);
        tick();
        check("t4_pp4_a", ifid_pc_plus4, 32'h1C);
        drv(1'b1, 32'h0000_1820, 1'b0, 1'b0, 32'd0);
        tick();
        check("t4_pp4_b", ifid_pc_plus4, 32'h20);
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h103);
        check("t4_addr_pend", imem_addr, 32'h20);
        tick();
        check("t4_busy", 32'(fetch_busy), 32'd1);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_drain_addr", imem_addr, 32'h20);
        check("t4_flush_valid", 32'(ifid_valid), 32'd0);
        check("t4_flush_instr", ifid_instr, NOP);
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("t4_drain_addr2", imem_addr, 32'h20);
        check("t4_valid2", 32'(ifid_valid), 32'd0);
        drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        check("t4_drain_addr3", imem_addr, 32'h20);
        tick();
        check("t4_drop_valid", 32'(ifid_valid), 32'd0);
        check("t4_drop_instr", ifid_instr, NOP);
        check("t4_busy_clr", 32'(fetch_busy), 32'd0);
        check("t4_target", imem_addr, 32'h100);
        drv(1'b1, 32'h0000_2020, 1'b0, 1'b0, 32'd0);
        tick();
        check("t4_new_valid", 32'(ifid_valid), 32'd1);
        check("t4_new_pp4", ifid_pc_plus4, 32'h104);
        check("t4_new_instr", ifid_instr, 32'h0000_2020);

        // Redirect together with hazard in HELD
        drv(1'b1, 32'h0000_2820, 1'b1, 1'b0, 32'd0);
        check("t5_addr", imem_addr, 32'h104);
        tick();
        check("t5_busy", 32'(fetch_busy), 32'd1);
        check("t5_hold", ifid_instr, 32'h0000_2020);
        drv(1'b0, 32'd0, 1'b1, 1'b1, 32'h200);
        tick();
        check("t5_flush_valid", 32'(ifid_valid), 32'd0);
        check("t5_flush_instr", ifid_instr, NOP);
        check("t5_flush_opcode", 32'(ifid_opcode), 32'd0);
        check("t5_busy_clr", 32'(fetch_busy), 32'd0);
        check("t5_target", imem_addr, 32'h200);
        drv(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        tick();
        check("t5_bubble_stays", 32'(ifid_valid), 32'd0);
        check("t5_target2", imem_addr, 32'h200);
        drv(1'b1, 32'h0000_3020, 1'b0, 1'b0, 32'd0);
        tick();
        check("t5_new_valid", 32'(ifid_valid), 32'd1);
        check("t5_new_instr", ifid_instr, 32'h0000_3020);
        check("t5_new_pp4", ifid_pc_plus4, 32'h204);

        // Redirect with simultaneous ack, then PC wrap and mid-drain reset
        drv(1'b1, 32'hBADB_AD00, 1'b0, 1'b1, 32'hFFFF_FFFE);
        check("t6_addr", imem_addr, 32'h204);
        tick();
        check("t6_drop_valid", 32'(ifid_valid), 32'd0);
        check("t6_drop_instr", ifid_instr, NOP);
        check("t6_no_drain", 32'(fetch_busy), 32'd0);
        check("t6_target", imem_addr, 32'hFFFF_FFFC);
        drv(1'b1, 32'h0000_3820, 1'b0, 1'b0, 32'd0);
        tick();
        check("t6_wrap_valid", 32'(ifid_valid), 32'd1);
        check("t6_wrap_instr", ifid_instr, 32'h0000_3820);
        check("t6_wrap_pp4", ifid_pc_plus4, 32'h0000_0000);
        check("t6_wrap_addr", imem_addr, 32'h0000_0000);
        drv(1'b0, 32'd0, 1'b0, 1'b1, 32'h40);
        tick();
        check("t6_wait_busy", 32'(fetch_busy), 32'd1);
        check("t6_wait_addr", imem_addr, 32'h0000_0000);
        rst_n = 1'b0;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        check("t6_rst_valid", 32'(ifid_valid), 32'd0);
        check("t6_rst_instr", ifid_instr, NOP);
        check("t6_rst_busy", 32'(fetch_busy), 32'd0);
        check("t6_rst_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        drv(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check("t6_start_req", 32'(imem_req), 32'd0);
        tick();
        check("t6_req_after", 32'(imem_req), 32'd1);
        check("t6_reset_pc", imem_addr, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_fetch_ifid.md
Name: cpu_fetch_ifid

Overview:
- Instruction fetch stage and IF/ID pipeline register for the 32-bit MIPS pipeline.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Latches fetched words into IF/ID and presents the opcode to the main control decoder.
- Honours hazard stalls and branch/jump redirects (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_INSTR, 32'h0000_0000, instruction word driven when IF/ID holds a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  rdata valid this cycle; may be high in the same cycle req first rises.
- imem_rdata  in  32  fetched instruction; sampled only when imem_req&imem_ack.
- hazard_detected  in  1  stall: hold PC and IF/ID contents.
- redirect_valid  in  1  taken branch/jump; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored, forced to 0.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  IF/ID instruction; NOP_INSTR when ifid_valid=0.
- ifid_opcode  out  6  ifid_instr[31:26]; feeds main control.
- ifid_pc_plus4  out  32  PC of the IF/ID instruction plus 4.
- fetch_busy  out  1  high in WAIT_DRAIN or HELD.

Behaviour:
- State machine: START, REQ, HELD, WAIT_DRAIN.
- Reset (rst_n=0 at edge), also mid-operation:
  - state=START, pc=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, skid buffer cleared.
  - Any outstanding memory request is abandoned. Imem must tolerate req dropping.
- imem_req:
  - 1 in REQ and WAIT_DRAIN, 0 in START and HELD.
  - imem_addr=pc in REQ; imem_addr=drain_addr in WAIT_DRAIN.
- START: go to REQ next cycle. imem_req=0 during START.
- REQ, priority order:
  1. redirect_valid: pc<=redirect_pc&~3; ifid_valid<=0.
     - If ack this cycle: data dropped, stay REQ.
     - Else: drain_addr<=pc, go WAIT_DRAIN.
  2. ack & ~hazard: ifid_instr<=rdata; ifid_pc_plus4<=pc+4; ifid_valid<=1; pc<=pc+4; stay REQ. This gives back-to-back throughput of 1 instruction per cycle with zero-wait memory.
  3. ack & hazard: skid<=rdata; IF/ID unchanged; go HELD. PC advances only when skid is consumed.
  4. ~ack & hazard: IF/ID unchanged.
  5. ~ack & ~hazard: ifid_valid<=0 (bubble), ifid_instr<=NOP_INSTR.
- HELD:
  - redirect_valid: flush IF/ID, discard skid, pc<=redirect_pc, go REQ.
  - Else if ~hazard: IF/ID<=skid with pc_plus4=pc+4, valid=1; pc<=pc+4; go REQ.
  - Else hold.
- WAIT_DRAIN: hold req on drain_addr until ack, discard rdata, then go REQ.
  - Further redirect_valid here updates pc only; stay WAIT_DRAIN.
  - ifid_valid stays 0.
- Redirect overrides hazard in every state.
- Hazard only freezes IF/ID while ifid_valid=1 or a stall is in progress. Flushed bubbles stay bubbles.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000. ifid_pc_plus4 wraps identically.
- Every instruction reaching IF/ID is fetched exactly once and in order. No instruction after a redirect from the old path may appear with ifid_valid=1.
- ifid_opcode is purely combinational from ifid_instr.

Test Plan:
- Reset then zero-wait ack every cycle, RESET_PC=0 -> imem_addr 0,4,8,C on consecutive cycles; ifid_pc_plus4 4,8,C one cycle after each address; ifid_valid continuous from cycle 2.
- ack delayed 3 cycles on addr 0x10 -> addr stable 4 cycles; ifid_valid=0 for 3 cycles; then instr valid with pc_plus4=0x14.
- hazard_detected high 2 cycles while ack returns word 0xAC010004 -> state HELD; IF/ID holds prior instr; after release ifid_instr=0xAC010004, ifid_opcode=6'b101011; no word lost or duplicated.
- redirect_valid with redirect_pc=0x103 while request to 0x20 is pending -> req stays on 0x20 until ack, data dropped; next request addr 0x100; ifid_valid=0 through drain.
- redirect and hazard asserted together in HELD -> skid discarded; IF/ID flushed to NOP_INSTR/opcode 0; next fetch at redirect target.
- pc=0xFFFFFFFC fetch then rst_n low mid-WAIT -> pc_plus4=0x00000000 on wrap; after reset imem_req=0 for one cycle, then addr=RESET_PC.
